sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 143 ++++++++++++++
 tb/tb_sum_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Purpose:
//   Accumulates a frame of nibble-sum samples and presents the frame total and
//   sample count to a downstream consumer with a valid/ready handshake. The
//   frame length is captured on the first accepted sample of each frame. A
//   length field of 0 means 2**CNT_W samples. While a result is pending
//   (HOLD), no new samples are accepted.
//
// Parameters:
//   SUM_W  width of each incoming sample
//   CNT_W  width of the frame-length field (maximum frame 2**CNT_W samples)
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   upstream sample valid
//   in_sum     in   upstream sample [SUM_W]
//   in_ready   out  sample accepted this cycle when in_valid is high
//   frame_len  in   samples per frame [CNT_W], 0 encodes 2**CNT_W
//   clear      in   synchronous abort of the current frame
//   out_valid  out  frame result available
//   out_ready  in   downstream accepts the result
//   out_total  out  accumulated frame sum [SUM_W+CNT_W]
//   out_count  out  number of samples in the frame [CNT_W+1]
// ---------------------------------------------------------------------------
module sum_accumulator #(
   parameter int SUM_W = 5,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [SUM_W-1:0]       in_sum,
   output logic                   in_ready,
   input  logic [CNT_W-1:0]       frame_len,
   input  logic                   clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SUM_W+CNT_W-1:0] out_total,
   output logic [CNT_W:0]         out_count
);

   localparam int TOT_W = SUM_W + CNT_W;

   // 2**CNT_W in CNT_W+1 bits, used when frame_len encodes a full frame as 0.
   localparam logic [CNT_W:0] FULL_LEN = {1'b1, {CNT_W{1'b0}}};
   localparam logic [CNT_W:0] ONE_CNT  = (CNT_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [TOT_W-1:0]     acc_q,   acc_d;
   logic [CNT_W:0]       cnt_q,   cnt_d;
   logic [CNT_W:0]       len_q,   len_d;

   logic                 accept;
   logic [TOT_W-1:0]     sample_ext;
   logic [CNT_W:0]       len_first;

   // Handshake flags come from registered state only, so in_ready never
   // depends combinationally on in_valid or clear.
   assign in_ready  = (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid && in_ready;

   // The accumulator is wide enough for 2**CNT_W full-scale samples, so
   // zero-extending each sample before adding cannot overflow.
   assign sample_ext = {{CNT_W{1'b0}}, in_sum};
   assign len_first  = (frame_len == '0) ? FULL_LEN : {1'b0, frame_len};

   // Outside HOLD these simply show whatever the accumulator holds; the
   // consumer only looks at them while out_valid is high.
   assign out_total = acc_q;
   assign out_count = cnt_q;

   // NOTE: every signal assigned in this block gets a default first so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;

      if (clear) begin
         // Abort wins over sample accept and over the result handshake; a
         // sample presented in the same cycle is taken but thrown away.
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  acc_d   = sample_ext;
                  cnt_d   = ONE_CNT;
                  len_d   = len_first;
                  state_d = (len_first == ONE_CNT) ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_d = acc_q + sample_ext;
                  cnt_d = cnt_q + ONE_CNT;
                  if (cnt_d == len_q) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its next value from the same pre-edge snapshot.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Self-checking bench for sum_accumulator. Each cycle the bench drives inputs
// on the falling edge, compares the outputs against a frame-level reference
// model just after, and advances the model on the rising edge. The model keeps
// the accepted samples of the current frame in a queue and forms the expected
// result as the plain sum of that queue once the frame length is reached.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

   localparam int SUM_W = 5;
   localparam int CNT_W = 4;
   localparam int TOT_W = SUM_W + CNT_W;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [SUM_W-1:0] in_sum;
   logic             in_ready;
   logic [CNT_W-1:0] frame_len;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [TOT_W-1:0] out_total;
   logic [CNT_W:0]   out_count;

   sum_accumulator #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sum    (in_sum),
      .in_ready  (in_ready),
      .frame_len (frame_len),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_total (out_total),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int  frame_q[$];       // samples accepted so far in the current frame
   int  target   = 0;     // frame length captured on the first sample
   bit  pending  = 1'b0;  // a result is waiting for the consumer
   bit  post_rst = 1'b0;  // previous edge was a reset edge
   bit  known    = 1'b0;  // model is meaningful (after the first reset)
   int  exp_total = 0;
   int  exp_count = 0;
   int  results   = 0;    // frames delivered, for a sanity check at the end

   task automatic check_outputs();
      if (!known) return;
      checks++;
      assert (in_ready === !pending) else begin
         errors++;
         $error("FAIL in_ready observed=%0b expected=%0b t=%0t", in_ready, !pending, $time);
      end
      checks++;
      assert (out_valid === pending) else begin
         errors++;
         $error("FAIL out_valid observed=%0b expected=%0b t=%0t", out_valid, pending, $time);
      end
      if (pending || post_rst) begin
         checks++;
         assert (out_total === TOT_W'(exp_total)) else begin
            errors++;
            $error("FAIL out_total observed=%0d expected=%0d t=%0t", out_total, exp_total, $time);
         end
         checks++;
         assert (out_count === (CNT_W+1)'(exp_count)) else begin
            errors++;
            $error("FAIL out_count observed=%0d expected=%0d t=%0t", out_count, exp_count, $time);
         end
      end
   endtask

   // Advance the model by one clock edge using the inputs held across it.
   task automatic model_edge(input bit rst, input bit iv, input int s,
                             input int fl, input bit clr, input bit ordy);
      post_rst = 1'b0;
      if (rst) begin
         frame_q.delete();
         pending   = 1'b0;
         exp_total = 0;
         exp_count = 0;
         post_rst  = 1'b1;
         known     = 1'b1;
      end else if (clr) begin
         frame_q.delete();
         pending = 1'b0;
      end else if (pending) begin
         if (ordy) begin
            pending = 1'b0;
            results++;
         end
      end else if (iv) begin
         if (frame_q.size() == 0) target = (fl == 0) ? (1 << CNT_W) : fl;
         frame_q.push_back(s);
         if (frame_q.size() == target) begin
            exp_total = 0;
            foreach (frame_q[i]) exp_total += frame_q[i];
            exp_count = frame_q.size();
            frame_q.delete();
            pending = 1'b1;
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit iv, input int s, input int fl,
                        input bit clr, input bit ordy);
      @(negedge clk);
      reset     = rst;
      in_valid  = iv;
      in_sum    = SUM_W'(s);
      frame_len = CNT_W'(fl);
      clear     = clr;
      out_ready = ordy;
      #1;
      check_outputs();
      @(posedge clk);
      model_edge(rst, iv, s, fl, clr, ordy);
   endtask

   // Convenience: one data cycle with out_ready high, no reset/clear.
   task automatic send(input int s, input int fl);
      cycle(1'b0, 1'b1, s, fl, 1'b0, 1'b1);
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, 1'b0, 0, 0, 1'b0, ordy);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_sum = '0; frame_len = '0;
      clear = 1'b0; out_ready = 1'b0;

      // Reset, then reset-state check on the following cycles.
      cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      idle(1'b0);

      // Three-sample frame, result handshaken immediately.
      send(5, 3); send(10, 3); send(30, 3);
      idle(1'b1);              // HOLD: 45 / 3
      idle(1'b1);              // back in IDLE, out_valid low
      idle(1'b1);

      // Full-length frame of full-scale samples: 16 * 31 = 496.
      for (int i = 0; i < 16; i++) send(31, 0);
      idle(1'b1);
      idle(1'b0);

      // Single-sample frame held for five cycles with upstream still pushing.
      send(7, 1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3, 1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Gaps mid-frame and frame_len changed after the first sample.
      send(1, 4); send(2, 4);
      idle(1'b0); idle(1'b0); idle(1'b0);
      send(3, 2); send(4, 2);
      idle(1'b1);              // HOLD: 10 / 4
      idle(1'b0);

      // Clear with a sample on the same cycle, then a fresh frame.
      send(9, 4); send(9, 4);
      cycle(1'b0, 1'b1, 9, 4, 1'b1, 1'b1);
      idle(1'b1);
      send(1, 4); send(1, 4); send(1, 4); send(1, 4);
      idle(1'b1);              // HOLD: 4 / 4
      idle(1'b0);

      // Clear while holding a result beats the out_ready handshake.
      send(6, 1);
      cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
      idle(1'b1);

      // Reset while holding a result discards it.
      send(12, 1);
      idle(1'b0);
      cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      idle(1'b1);              // out_total 0, in_ready 1, out_valid 0
      idle(1'b1);

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, (1 << SUM_W) - 1)),
               int'($urandom_range(0, (1 << CNT_W) - 1)),
               ($urandom_range(0, 59) == 0),
               ($urandom_range(0, 2) != 0));
      end
      idle(1'b1);
      idle(1'b1);

      checks++;
      assert (results > 10) else begin
         errors++;
         $error("FAIL frames_delivered observed=%0d expected=>10", results);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
